// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shifter for the ALU shift path.
// Accepts one request through a start/busy/done handshake. The operand is
// then shifted a little each cycle until the requested count is used up.
// Supported ops: SRL, SLL, SRA, and a fixed left shift for LUI immediates.
// Optional build macro SHIFT_FAST_EN: shift 4 bits per cycle while at
// least 4 positions remain. Without it, every step is 1 bit.
module shift_sequencer #(
  parameter int XLEN      = 32,
  parameter int LUI_SHAMT = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] operand,
  input  logic [4:0]      shamt,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

  localparam logic [1:0] OP_SRL  = 2'b00;
  localparam logic [1:0] OP_SLL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_LUI  = 2'b11;
  localparam logic [4:0] LUI_CNT = 5'(LUI_SHAMT);

  state_e            state_q;
  logic [1:0]        op_q;
  logic [XLEN-1:0]   acc_q;
  logic [XLEN-1:0]   acc_d;
  logic [4:0]        cnt_q;
  logic [4:0]        cnt_d;
  logic [4:0]        cnt_load_s;
  logic [XLEN-1:0]   acc_step1_s;
  logic              busy_q;
  logic              done_q;
`ifdef SHIFT_FAST_EN
  logic [XLEN-1:0]   acc_step4_s;
`endif

  // Pick the initial count: LUI-shift ignores shamt and uses the fixed amount
  always_comb begin
    cnt_load_s = shamt;
    if (op == OP_LUI) begin
      cnt_load_s = LUI_CNT;
    end else begin
      cnt_load_s = shamt;
    end
  end

  // Single-bit step, with the fill bit chosen by the latched op
  always_comb begin
    acc_step1_s = acc_q;
    case (op_q)
      OP_SRL:  acc_step1_s = {1'b0, acc_q[XLEN-1:1]};
      OP_SLL:  acc_step1_s = {acc_q[XLEN-2:0], 1'b0};
      OP_SRA:  acc_step1_s = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
      OP_LUI:  acc_step1_s = {acc_q[XLEN-2:0], 1'b0};
      default: acc_step1_s = acc_q;
    endcase
  end

`ifdef SHIFT_FAST_EN
  // Four-bit step, with the same fill rules as the single-bit step
  always_comb begin
    acc_step4_s = acc_q;
    case (op_q)
      OP_SRL:  acc_step4_s = {4'b0000, acc_q[XLEN-1:4]};
      OP_SLL:  acc_step4_s = {acc_q[XLEN-5:0], 4'b0000};
      OP_SRA:  acc_step4_s = {{4{acc_q[XLEN-1]}}, acc_q[XLEN-1:4]};
      OP_LUI:  acc_step4_s = {acc_q[XLEN-5:0], 4'b0000};
      default: acc_step4_s = acc_q;
    endcase
  end

  // Next accumulator and count: use a wide step while at least 4 positions remain
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (cnt_q >= 5'd4) begin
      acc_d = acc_step4_s;
      cnt_d = cnt_q - 5'd4;
    end else if (cnt_q != 5'd0) begin
      acc_d = acc_step1_s;
      cnt_d = cnt_q - 5'd1;
    end else begin
      acc_d = acc_q;
      cnt_d = cnt_q;
    end
  end
`else
  // Next accumulator and count: one bit per cycle
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (cnt_q != 5'd0) begin
      acc_d = acc_step1_s;
      cnt_d = cnt_q - 5'd1;
    end else begin
      acc_d = acc_q;
      cnt_d = cnt_q;
    end
  end
`endif

  // Handshake FSM. busy and done are registered: done pulses on the edge that leaves DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
      acc_q   <= '0;
      cnt_q   <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        // Cancel: acc keeps its partial value and no done is produced
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              acc_q  <= operand;
              op_q   <= op;
              cnt_q  <= cnt_load_s;
              busy_q <= 1'b1;
              if (cnt_load_s != 5'd0) begin
                state_q <= S_SHIFT;
              end else begin
                state_q <= S_DONE;
              end
            end else begin
              state_q <= S_IDLE;
            end
          end
          S_SHIFT: begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (cnt_d == 5'd0) begin
              state_q <= S_DONE;
            end else begin
              state_q <= S_SHIFT;
            end
          end
          S_DONE: begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = acc_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed testbench for shift_sequencer. Expected results are queued when a
// request is driven and popped when done pulses. Latencies are computed from
// the shift count for whichever step mode is built.
module tb_shift_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand;
  logic [4:0]  shamt;
  logic        abort;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          n_tests  = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  logic [31:0] exp_q[$];

  shift_sequencer #(.XLEN(32), .LUI_SHAMT(12)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .operand (operand),
    .shamt   (shamt),
    .abort   (abort),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every done pulse seen
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  function automatic int shift_cycles(input int n);
`ifdef SHIFT_FAST_EN
    return (n / 4) + (n % 4);
`else
    return n;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop_check(input string tag);
    logic [31:0] e;
    check({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_result"}, result, e);
    end
  endtask

  // Call at a negedge. Drives one request, waits for done and checks result and timing.
  task automatic do_req(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [4:0] s, input logic [31:0] exp, input int n_eff);
    int cyc;
    int busy_cnt;
    bit seen;
    start = 1'b1; op = o; operand = a; shamt = s;
    exp_q.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    cyc = 1; busy_cnt = 0; seen = 1'b0;
    while (!seen && cyc < 100) begin
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (busy === 1'b1) busy_cnt++;
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(shift_cycles(n_eff) + 2));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(shift_cycles(n_eff) + 1));
    check({tag, "_busy_low_at_done"}, 32'(busy), 32'd0);
    sb_pop_check(tag);
    @(negedge clk);
    check({tag, "_done_one_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int d0;
    int cyc;
    bit seen;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; operand = 32'h0; shamt = 5'd0; abort = 1'b0;
    #12;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_req("srl4", 2'b00, 32'h8000_00F0, 5'd4, 32'h0800_000F, 4);
    do_req("sra31", 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 31);
    do_req("lui", 2'b11, 32'h0000_0ABC, 5'd5, 32'h00AB_C000, 12);
    do_req("zero", 2'b01, 32'h1234_5678, 5'd0, 32'h1234_5678, 0);
    do_req("sra_pos", 2'b10, 32'h4000_0000, 5'd3, 32'h0800_0000, 3);
    do_req("sll9", 2'b01, 32'h0000_0001, 5'd9, 32'h0000_0200, 9);

    // Second start during SHIFT must be ignored
    #1 d0 = done_cnt;
    start = 1'b1; op = 2'b01; operand = 32'h0000_0003; shamt = 5'd6;
    exp_q.push_back(32'h0000_00C0);
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; op = 2'b00; operand = 32'hFFFF_FFFF; shamt = 5'd1;
    @(negedge clk); start = 1'b0;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 40) begin
      if (done === 1'b1) seen = 1'b1;
      else begin @(negedge clk); cyc++; end
    end
    check("ign_done_seen", 32'(seen), 32'd1);
    sb_pop_check("ign");
    repeat (10) @(negedge clk);
    #1;
    check("ign_one_done", 32'(done_cnt - d0), 32'd1);
    @(negedge clk);

    // Abort on the third SHIFT cycle of SLL by 10
    #1 d0 = done_cnt;
    start = 1'b1; op = 2'b01; operand = 32'h0000_0001; shamt = 5'd10;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
`ifdef SHIFT_FAST_EN
    check("abort_partial", result, 32'h0000_0100);
`else
    check("abort_partial", result, 32'h0000_0004);
`endif
    do_req("post_abort", 2'b00, 32'h0000_00F0, 5'd4, 32'h0000_000F, 4);
    #1;
    check("abort_no_done", 32'(done_cnt - d0), 32'd1);
    @(negedge clk);

    // abort wins over start in IDLE
    start = 1'b1; abort = 1'b1; op = 2'b00; operand = 32'hDEAD_BEEF; shamt = 5'd3;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check("abort_prio_busy", 32'(busy), 32'd0);
    check("abort_prio_result", result, 32'h0000_000F);

    // Asynchronous reset mid-SHIFT
    #1 d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; op = 2'b10; operand = 32'h8000_0000; shamt = 5'd20;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_result", result, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    check("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
    @(negedge clk);
    do_req("post_rst", 2'b01, 32'h0000_0001, 5'd1, 32'h0000_0002, 1);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle controller for the ALU's shift path: it accepts one shift request via a start/busy/done handshake and iterates the operand one bit position per cycle. It supports SRL, SLL, SRA, and the fixed 12-bit left shift used for LUI immediates. It sits between the single-cycle control unit and the ALU result mux. It replaces the unrolled combinational shift chain so the shift path no longer limits the cycle time. Control stalls the PC while `busy` is high.

## Interface
Parameters:
- `XLEN`, 32: operand and result width.
- `LUI_SHAMT`, 12: fixed shift amount for op `2'b11`.

Ports:
- `clk`  in  1: system clock, rising-edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: request strobe; accepted only in IDLE.
- `op`  in  2: `00` SRL, `01` SLL, `10` SRA, `11` LUI-shift (SLL by `LUI_SHAMT`).
- `operand`  in  XLEN: value to shift (rs1 or immediate).
- `shamt`  in  5: shift amount; ignored for op `11`.
- `abort`  in  1: synchronous cancel, for pipeline flush or trap.
- `busy`  out  1: high from the accept edge until the edge before `done`.
- `done`  out  1: one-cycle pulse; `result` is valid.
- `result`  out  XLEN: shifted value; holds until the next accept.

## Operation
- States: IDLE, SHIFT, DONE.
- **IDLE**
  - On `start=1`, latch `operand` into `acc` and latch `op`.
  - Load `cnt` with `shamt` for ops `00`/`01`/`10`, or with `LUI_SHAMT` for op `11`.
  - Go to SHIFT if `cnt != 0`, otherwise go to DONE.
  - `start=0` stays in IDLE.
- **SHIFT**, each cycle:
  - SRL: `acc <= {1'b0, acc[XLEN-1:1]}`.
  - SLL and LUI-shift: `acc <= {acc[XLEN-2:0], 1'b0}`.
  - SRA: `acc <= {acc[XLEN-1], acc[XLEN-1:1]}`.
  - Decrement `cnt` by the step size. When the post-step `cnt` is 0, go to DONE.
- **DONE**: assert `done` for one cycle, then return to IDLE. `start` in DONE is ignored.
- `result` is `acc`. It is visible while shifting but only architecturally valid when `done=1`.
- `start` during SHIFT or DONE is ignored; it is not queued.
- `abort=1` in any state forces IDLE on the next edge and suppresses `done`. `acc` keeps its partial value.
- `abort` has priority over `start` when both are high in IDLE.
- `shamt` is 5 bits, so a request is at most 31 shifts. Upper bits of a wider source are truncated by the caller.

## Timing
Reset values (asynchronous on `rst_n=0`): state=IDLE, `busy=0`, `done=0`, `result=0`, `cnt=0`.

Latency from the accept edge E, with N = effective shift count:
- SHIFT occupies edges E+1 through E+N.
- `done` is high in the cycle after edge E+N+1. This gives N+2 cycles from `start` to the `done` sample.
- N=0 goes straight to DONE: `done` is high after edge E+1, with `result` equal to `operand`.
- The next `start` is accepted no earlier than the cycle in which `done` is high plus one (back in IDLE). Throughput is one request per N+2 cycles.

`busy` is registered: it is 1 in the cycles following E through the SHIFT cycles, and 0 in the DONE cycle.

Reset mid-operation: `rst_n` low during SHIFT clears all state immediately, and no `done` is produced.

## Configuration
`SHIFT_FAST_EN`:
- **Defined**: in SHIFT, step 4 bits per cycle when `cnt >= 4`, otherwise 1 bit. SHIFT therefore lasts `N/4 + N%4` cycles (integer division). Fill bits are the same per op (zero, or sign for SRA).
- **Undefined**: fixed 1-bit step as described above.

The handshake, the reset values, and the N=0 path are identical in both builds.

## Test plan
- SRL: `operand=0x8000_00F0`, `shamt=4` → `done` 6 cycles after `start`; `result=0x0800_000F`.
- SRA: `operand=0x8000_0000`, `shamt=31` → `result=0xFFFF_FFFF`; `busy` high for 32 cycles.
- LUI-shift: `op=11`, `operand=0x0000_0ABC`, `shamt=5` (ignored) → `result=0x00AB_C000` after 14 cycles.
- Zero shift and ignored start:
  - `shamt=0`, `operand=0x1234_5678` → `done` one cycle after accept; `result=0x1234_5678`.
  - A second `start` pulsed during SHIFT of another request is ignored: exactly one `done` pulse.
- Abort and reset:
  - `abort` asserted on the 3rd SHIFT cycle of an SLL by 10 → no `done`; IDLE next cycle; a new request is accepted immediately after.
  - `rst_n` pulsed low mid-SHIFT → all outputs 0 asynchronously.
- `SHIFT_FAST_EN` build: SLL `operand=1`, `shamt=9` → SHIFT lasts 3 cycles; `result=0x0000_0200`.
